and_sweep_ctrl: RTL and testbench

AND_SWEEP_CTRL -- requirements
Module: and_sweep_ctrl

---
 rtl/and_sweep_ctrl.sv | 146 ++++++++++++++
 tb/tb_and_sweep_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/and_sweep_ctrl.sv
// Exhaustive 2-input sweep controller for an external AND datapath: drives each {a,b}, waits, checks f.
// Optional macro AND_SWEEP_FAILCNT_EN adds a saturating fail_count[2:0] output.
module and_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 20,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       a,
  output logic       b,
  input  logic       f,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_vec
`ifdef AND_SWEEP_FAILCNT_EN
  ,
  output logic [2:0] fail_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_q, a_d, b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [3:0]       err_q, err_d;
  logic [2:0]       fc_q, fc_d;
  logic             mismatch;

  assign mismatch = f != (a_q & b_q);

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fc_d    = fc_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = DRIVE;
          idx_d   = 2'd0;
          err_d   = 4'b0000;
          pass_d  = 1'b0;
          fc_d    = 3'd0;
        end
      end
      DRIVE: begin
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = CHECK;
      end
      CHECK: begin
        if (mismatch) begin
          err_d[idx_q] = 1'b1;
          if (fc_q != 3'd4) fc_d = fc_q + 3'd1;
        end
        if (idx_q == 2'd3) begin
          state_d = DONE;
          pass_d  = ~|err_d;
        end else begin
          state_d = DRIVE;
          idx_d   = idx_q + 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort drops the in-flight check; err_vec keeps only completed vectors.
    if (abort && (state_q inside {DRIVE, SETTLE, CHECK})) begin
      state_d = IDLE;
      pass_d  = 1'b0;
      err_d   = err_q;
      fc_d    = fc_q;
    end

    // Operands follow idx for the whole vector, so they only change on a DRIVE entry.
    {a_d, b_d} = (state_d inside {DRIVE, SETTLE, CHECK}) ? idx_d : 2'b00;
    busy_d     = state_d != IDLE;
    done_d     = state_d == DONE;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 4'b0000;
      fc_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fc_q    <= fc_d;
    end
  end

  assign a       = a_q;
  assign b       = b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_vec = err_q;

`ifdef AND_SWEEP_FAILCNT_EN
  assign fail_count = fc_q;
`else
  logic unused_fc;
  assign unused_fc = ^fc_q;
`endif

endmodule

// File: tb/tb_and_sweep_ctrl.sv
// Self-checking bench for and_sweep_ctrl (SETTLE_CYCLES=2): fault-mask table plus abort/reset corner cases.
module tb_and_sweep_ctrl;

  localparam int S     = 2;
  localparam int VLEN  = S + 2;
  localparam int SWEEP = 4 * VLEN;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic       a, b, f, busy, done, pass;
  logic [3:0] err_vec;
  logic [3:0] flip_mask;
`ifdef AND_SWEEP_FAILCNT_EN
  logic [2:0] fail_count;
`endif

  // Datapath model: ideal AND with per-vector output inversion to inject faults.
  assign f = (a & b) ^ flip_mask[{a, b}];

  always #5 clk = ~clk;

  and_sweep_ctrl #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .a(a), .b(b), .f(f), .busy(busy), .done(done), .pass(pass), .err_vec(err_vec)
`ifdef AND_SWEEP_FAILCNT_EN
    , .fail_count(fail_count)
`endif
  );

  typedef struct {
    logic [3:0] err;
    logic       pass;
    logic [2:0] fc;
  } exp_t;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] err;
    logic       pass;
    logic [2:0] fc;
    bit         start_in_done;
    bit         abort_in_done;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[6];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic run_sweep(input string tag, input vec_t v);
    exp_t e;
    bit   seq_ok = 1'b1;
    bit   seen   = 1'b0;
    int   n      = 1;
    flip_mask = v.mask;
    sb_q.push_back('{v.err, v.pass, v.fc});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    forever begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (n > SWEEP + 20) break;
      if (n <= SWEEP && ({a, b} != 2'((n - 1) / VLEN) || !busy)) seq_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, "_ab_seq"}, 32'(seq_ok), 32'd1);
    check({tag, "_latency"}, n, SWEEP + 1);
    if (seen && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_err_vec"}, 32'(err_vec), 32'(e.err));
      check({tag, "_pass"}, 32'(pass), 32'(e.pass));
`ifdef AND_SWEEP_FAILCNT_EN
      check({tag, "_fail_count"}, 32'(fail_count), 32'(e.fc));
`endif
    end else begin
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
    start = v.start_in_done;
    abort = v.abort_in_done;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check({tag, "_after_done"}, {busy, done}, 2'b00);
    repeat (5) @(negedge clk);
    check({tag, "_hold_idle"}, {busy, pass, err_vec}, {1'b0, v.pass, v.err});
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    bit bad = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (done || busy) bad = 1'b1;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  // Start a sweep and abort it in the first SETTLE cycle of vector 1.
  task automatic abort_sweep(input string tag, input logic [3:0] mask, input logic [3:0] exp_err);
    flip_mask = mask;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (VLEN + 1) @(negedge clk);
    check({tag, "_in_settle"}, {busy, a, b}, 3'b101);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check({tag, "_state"}, {busy, done, a, b, pass, err_vec}, {5'b00000, exp_err});
    expect_quiet({tag, "_no_done"}, SWEEP + 10);
    check({tag, "_err_held"}, 32'(err_vec), 32'(exp_err));
  endtask

  initial begin
    vecs[0] = '{4'b0000, 4'b0000, 1'b1, 3'd0, 1'b0, 1'b1};  // ideal; abort in DONE ignored
    vecs[1] = '{4'b0111, 4'b0111, 1'b0, 3'd3, 1'b0, 1'b0};  // f stuck at 1
    vecs[2] = '{4'b1000, 4'b1000, 1'b0, 3'd1, 1'b1, 1'b0};  // f stuck at 0; start in DONE ignored
    vecs[3] = '{4'b0101, 4'b0101, 1'b0, 3'd2, 1'b0, 1'b0};
    vecs[4] = '{4'b1111, 4'b1111, 1'b0, 3'd4, 1'b0, 1'b0};
    vecs[5] = '{4'b0000, 4'b0000, 1'b1, 3'd0, 1'b0, 1'b0};  // pass recovers after failures

    rst = 1'b1; start = 1'b1; abort = 1'b0; flip_mask = 4'b0000;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("reset_outputs", {a, b, busy, done, pass, err_vec}, 9'd0);
`ifdef AND_SWEEP_FAILCNT_EN
    check("reset_fail_count", 32'(fail_count), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {busy, done}, 2'b00);

    for (int i = 0; i < 6; i++) run_sweep($sformatf("vec%0d", i), vecs[i]);

    abort_sweep("abort_ideal", 4'b0000, 4'b0000);
    abort_sweep("abort_partial", 4'b0001, 4'b0001);

    // Reset mid-sweep, then a fresh sweep runs normally.
    flip_mask = 4'b0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_outputs", {a, b, busy, done, pass, err_vec}, 9'd0);
    expect_quiet("rst_mid_no_done", 10);
    run_sweep("after_rst", vecs[0]);

    // start and abort together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    expect_quiet("start_abort_quiet", 8);
    run_sweep("after_start_abort", vecs[3]);

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
